exe_muldiv_unit: RTL

Iterative RV32M multiply/divide execution unit in the execute stage. It sits directly upstream of the execute→write-back latch and drives that latch's data, destination, enable, instruction and PC inputs. It accepts one operation at a time from decode and returns a single registered write-back pulse after a fixed latency. While it works, it raises busy so the front end stalls.

---
 rtl/exe_muldiv_unit.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/exe_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one radix-2 step per cycle, fixed
// 33-cycle latency from acceptance to a single registered write-back pulse.
module exe_muldiv_unit (
  input  logic        clk_i,
  input  logic        rsn_i,
  input  logic        dec_valid_i,
  input  logic [2:0]  dec_funct3_i,
  input  logic [31:0] dec_rs1_data_i,
  input  logic [31:0] dec_rs2_data_i,
  input  logic [4:0]  dec_write_addr_i,
  input  logic [31:0] dec_instruction_i,
  input  logic [31:0] dec_pc_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic [31:0] exe_int_write_data_o,
  output logic [4:0]  exe_write_addr_o,
  output logic        exe_int_write_enable_o,
  output logic [31:0] exe_instruction_o,
  output logic [31:0] exe_pc_o
);

  localparam int XLEN    = 32;
  localparam int LATENCY = 33;  // E0 accept, E1..E32 steps, E33 write-back
  localparam int STEPS   = LATENCY - 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  typedef struct packed {
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [4:0]      addr;
    logic [31:0]     instr;
    logic [31:0]     pc;
  } req_t;

  state_t            state_q, state_d;
  logic [4:0]        cnt_q;
  req_t              req_q;
  logic [2*XLEN-1:0] acc_q;     // mul: {product hi, multiplier/lo}; div: {rem, quotient}
  logic [XLEN-1:0]   mb_q;      // multiplicand or divisor magnitude
  logic              neg_q;     // product / quotient sign
  logic              neg_rem_q; // remainder sign (dividend sign)

  logic accept;
  assign accept = (state_q == IDLE) && dec_valid_i && !flush_i;
  assign busy_o = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    if (flush_i) state_d = IDLE;
               else if (cnt_q == 5'(STEPS - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand conditioning at acceptance
  logic            in_div, a_signed, b_signed, sa, sb;
  logic [XLEN-1:0] mag_a, mag_b;

  always_comb begin
    in_div   = dec_funct3_i[2];
    a_signed = in_div ? !dec_funct3_i[0] : (dec_funct3_i[1:0] != 2'b11);
    b_signed = in_div ? !dec_funct3_i[0] : !dec_funct3_i[1];
    sa       = a_signed && dec_rs1_data_i[XLEN-1];
    sb       = b_signed && dec_rs2_data_i[XLEN-1];
    mag_a    = sa ? (~dec_rs1_data_i + 1'b1) : dec_rs1_data_i;
    mag_b    = sb ? (~dec_rs2_data_i + 1'b1) : dec_rs2_data_i;
  end

  // One iteration of shift-add multiply or restoring divide
  logic              is_div;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_sh;
  logic [XLEN+1:0]   div_diff;
  logic [2*XLEN-1:0] acc_step;

  always_comb begin
    is_div   = req_q.funct3[2];
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mb_q} : '0);
    div_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff = {1'b0, div_sh} - {2'b00, mb_q};
    if (!is_div)
      acc_step = {mul_sum, acc_q[XLEN-1:1]};
    else if (!div_diff[XLEN+1])
      acc_step = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    else
      acc_step = {div_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
  end

  // Sign fix-up and architectural special cases
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot, rem, result;
  logic              div0, ovf;

  always_comb begin
    prod = neg_q ? (~acc_q + 1'b1) : acc_q;
    quot = neg_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
    rem  = neg_rem_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
    div0 = (req_q.rs2 == '0);
    ovf  = !req_q.funct3[0] && (req_q.rs1 == {1'b1, {(XLEN-1){1'b0}}}) &&
           (req_q.rs2 == '1);
    case (req_q.funct3)
      3'b000:         result = prod[XLEN-1:0];
      3'b001, 3'b010,
      3'b011:         result = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101: result = div0 ? '1 : (ovf ? req_q.rs1 : quot);
      default:        result = div0 ? req_q.rs1 : (ovf ? '0 : rem);
    endcase
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      req_q     <= '0;
      acc_q     <= '0;
      mb_q      <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_q     <= '{funct3: dec_funct3_i, rs1: dec_rs1_data_i, rs2: dec_rs2_data_i,
                       addr: dec_write_addr_i, instr: dec_instruction_i, pc: dec_pc_i};
        cnt_q     <= '0;
        acc_q     <= {{XLEN{1'b0}}, mag_a};
        mb_q      <= mag_b;
        neg_q     <= sa ^ sb;
        neg_rem_q <= sa;
      end else if (state_q == CALC && !flush_i) begin
        cnt_q <= cnt_q + 5'd1;
        acc_q <= acc_step;
      end
    end
  end

  // Output registers hold between pulses; only the enable self-clears
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      exe_int_write_data_o   <= '0;
      exe_write_addr_o       <= '0;
      exe_int_write_enable_o <= 1'b0;
      exe_instruction_o      <= '0;
      exe_pc_o               <= '0;
    end else begin
      exe_int_write_enable_o <= 1'b0;
      if (state_q == DONE && !flush_i) begin
        exe_int_write_data_o   <= result;
        exe_write_addr_o       <= req_q.addr;
        exe_int_write_enable_o <= (req_q.addr != 5'd0);
        exe_instruction_o      <= req_q.instr;
        exe_pc_o               <= req_q.pc;
      end
    end
  end

endmodule
